// File: rtl/z_mux_arbiter_pkg.sv
// Shared types and state encodings for the two-requester mux arbiter.
package z_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_OWN_A = 2'b01,
        S_OWN_B = 2'b10
    } arb_state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/zn_2_1_mux.sv
// DATA_W-wide 2:1 mux built as a bank of per-bit select cells (sel 0 = a, 1 = b).
module zn_2_1_mux #(
    parameter int DATA_W = 4
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] y
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign y[i] = sel ? b_data[i] : a_data[i];
    end

endmodule

// File: rtl/z_mux_arbiter.sv
// Round-robin owner of a shared 2:1 data path with bounded tenure while the
// other requester waits; the selected data is registered with a valid strobe.
module z_mux_arbiter
    import z_mux_arbiter_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  hold_cnt, hold_d;
    logic              last, last_d;
    logic              sel_q, sel_d;
    logic              xfer;
    logic [DATA_W-1:0] mux_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    zn_2_1_mux #(.DATA_W(DATA_W)) u_mux (
        .sel    (sel_q),
        .a_data (a_data),
        .b_data (b_data),
        .y      (mux_data)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_cnt;
        last_d  = last;
        sel_d   = sel_q;
        xfer    = 1'b0;
        case (state_q)
            S_IDLE: begin
                hold_d = '0;
                if (req_a && req_b) begin
                    // last == B means A has priority on a tie
                    state_d = (last == OWNER_B) ? S_OWN_A : S_OWN_B;
                    sel_d   = (last == OWNER_B) ? OWNER_A : OWNER_B;
                end else if (req_a) begin
                    state_d = S_OWN_A;
                    sel_d   = OWNER_A;
                end else if (req_b) begin
                    state_d = S_OWN_B;
                    sel_d   = OWNER_B;
                end
            end
            S_OWN_A: begin
                if (req_a && !(hold_cnt == HOLD_MAX && req_b)) begin
                    xfer   = 1'b1;
                    hold_d = sat_inc(hold_cnt);
                end else begin
                    last_d  = OWNER_A;
                    hold_d  = '0;
                    state_d = req_b ? S_OWN_B : S_IDLE;
                    if (req_b) sel_d = OWNER_B;
                end
            end
            S_OWN_B: begin
                if (req_b && !(hold_cnt == HOLD_MAX && req_a)) begin
                    xfer   = 1'b1;
                    hold_d = sat_inc(hold_cnt);
                end else begin
                    last_d  = OWNER_B;
                    hold_d  = '0;
                    state_d = req_a ? S_OWN_A : S_IDLE;
                    if (req_a) sel_d = OWNER_A;
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q   <= S_IDLE;
            hold_cnt  <= '0;
            last      <= OWNER_B;
            sel_q     <= OWNER_A;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_cnt  <= hold_d;
            last      <= last_d;
            sel_q     <= sel_d;
            out_valid <= xfer;
            if (xfer) out_data <= mux_data;
        end
    end

    assign gnt_a = (state_q == S_OWN_A);
    assign gnt_b = (state_q == S_OWN_B);
    assign sel   = sel_q;

endmodule

// File: tb/tb_z_mux_arbiter.sv
// Directed bench for z_mux_arbiter with a tenure-level reference model.
module tb_z_mux_arbiter;
    import z_mux_arbiter_pkg::*;

    localparam int DATA_W   = 4;
    localparam int MAX_HOLD = 8;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              req_a = 1'b0, req_b = 1'b0;
    logic [DATA_W-1:0] a_data = '0, b_data = '0;
    logic              gnt_a, gnt_b, sel, out_valid;
    logic [DATA_W-1:0] out_data;

    int total = 0;
    int bad   = 0;

    // reference model: owner 0 = none, 1 = A, 2 = B
    int              m_owner   = 0;
    int              m_last    = 2;
    int              m_tenure  = 0;
    logic            m_valid   = 1'b0;
    logic [DATA_W-1:0] m_data  = '0;
    logic            m_sel     = 1'b0;

    always #5 clk = ~clk;

    z_mux_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req_a     (req_a),
        .req_b     (req_b),
        .a_data    (a_data),
        .b_data    (b_data),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic ra, input logic rb,
                              input logic [DATA_W-1:0] ad, input logic [DATA_W-1:0] bd);
        logic mine, other;
        if (!r) begin
            m_owner = 0; m_last = 2; m_tenure = 0;
            m_valid = 1'b0; m_data = '0; m_sel = 1'b0;
            return;
        end
        if (m_owner == 0) begin
            m_valid = 1'b0;
            if (ra && rb)  m_owner = (m_last == 2) ? 1 : 2;
            else if (ra)   m_owner = 1;
            else if (rb)   m_owner = 2;
            if (m_owner != 0) m_sel = (m_owner == 2);
            m_tenure = 0;
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (mine && !(m_tenure >= MAX_HOLD && other)) begin
                m_valid = 1'b1;
                m_data  = (m_owner == 1) ? ad : bd;
                m_tenure++;
            end else begin
                m_valid  = 1'b0;
                m_last   = m_owner;
                m_tenure = 0;
                m_owner  = other ? (3 - m_owner) : 0;
                if (m_owner != 0) m_sel = (m_owner == 2);
            end
        end
    endtask

    // drive one cycle, advance the model, then compare #1 after the edge
    task automatic step(input logic r, input logic ra, input logic rb,
                        input logic [DATA_W-1:0] ad, input logic [DATA_W-1:0] bd);
        rst_ = r; req_a = ra; req_b = rb; a_data = ad; b_data = bd;
        @(posedge clk);
        model_edge(r, ra, rb, ad, bd);
        #1;
        chk("gnt_a",     32'(gnt_a),     32'(m_owner == 1));
        chk("gnt_b",     32'(gnt_b),     32'(m_owner == 2));
        chk("sel",       32'(sel),       32'(m_sel));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("exclusive", 32'(gnt_a & gnt_b), 32'd0);
    endtask

    initial begin
        int cnt, first_b, b_seen;
        logic ra, rb;

        step(0, 0, 0, 4'h0, 4'h0);
        step(0, 0, 0, 4'h0, 4'h0);
        chk("reset_last", 32'(dut.last), 32'd1);

        // single requester
        step(1, 1, 0, 4'h3, 4'h0);
        chk("single_gnt", 32'({gnt_a, sel}), 32'b10);
        step(1, 1, 0, 4'h3, 4'h0);
        chk("single_data", 32'({out_valid, out_data}), 32'h13);
        step(1, 0, 0, 4'h3, 4'h0);
        step(1, 0, 0, 4'h0, 4'h0);

        // reset mid-transfer
        step(1, 1, 0, 4'h5, 4'h0);
        step(1, 1, 0, 4'h5, 4'h0);
        step(1, 1, 0, 4'h5, 4'h0);
        step(0, 1, 0, 4'h5, 4'h0);
        chk("rst_mid_outs", 32'({gnt_a, gnt_b, sel, out_valid, out_data}), 32'd0);
        chk("rst_mid_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("rst_mid_last", 32'(dut.last), 32'd1);

        // tie from reset, release handover, alternation
        step(1, 1, 1, 4'h1, 4'h9);
        chk("tie_first_a", 32'({gnt_a, gnt_b}), 32'b10);
        step(1, 1, 1, 4'h2, 4'h9);
        step(1, 1, 1, 4'h4, 4'h9);
        step(1, 0, 1, 4'h4, 4'h9);
        chk("release_bubble", 32'({out_valid, gnt_b, sel}), 32'b011);
        step(1, 0, 1, 4'h0, 4'hA);
        chk("b_data", 32'({out_valid, out_data}), 32'h1A);
        step(1, 0, 0, 4'h0, 4'hA);
        step(1, 1, 1, 4'h6, 4'hB);
        chk("tie_alternates", 32'({gnt_a, gnt_b}), 32'b10);
        step(1, 0, 0, 4'h6, 4'hB);
        step(1, 0, 0, 4'h0, 4'h0);

        // preemption from a fresh reset
        step(0, 0, 0, 4'h0, 4'h0);
        cnt = 0; first_b = 0; b_seen = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 1, 4'(i), 4'(~i));
            if (out_valid && !sel) cnt++;
            if (gnt_b && !b_seen) begin first_b = i; b_seen = 1; end
        end
        chk("preempt_count", 32'(cnt), 32'd8);
        chk("preempt_first_b", 32'(first_b), 32'd10);
        step(1, 0, 0, 4'h0, 4'h0);
        step(1, 0, 0, 4'h0, 4'h0);

        // lone requester keeps the path
        step(0, 0, 0, 4'h0, 4'h0);
        step(1, 1, 0, 4'h7, 4'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 4'(i), 4'h0);
            if (out_valid && gnt_a) cnt++;
        end
        chk("alone_count", 32'(cnt), 32'd20);
        chk("alone_hold_sat", 32'(dut.hold_cnt), 32'd8);

        // withdrawal of a pending request
        step(0, 0, 0, 4'h0, 4'h0);
        b_seen = 0;
        step(1, 1, 0, 4'h1, 4'h0);
        step(1, 1, 0, 4'h2, 4'h0);
        step(1, 1, 1, 4'h3, 4'hF);
        b_seen |= gnt_b;
        step(1, 1, 0, 4'h4, 4'h0);
        b_seen |= gnt_b;
        step(1, 0, 0, 4'h4, 4'h0);
        b_seen |= gnt_b;
        step(1, 0, 0, 4'h0, 4'h0);
        b_seen |= gnt_b;
        chk("withdraw_no_gnt_b", 32'(b_seen), 32'd0);
        chk("withdraw_idle", 32'(dut.state_q), 32'(S_IDLE));

        // mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            ra = 1'($urandom_range(0, 3) != 0);
            rb = 1'($urandom_range(0, 2) != 0);
            step(1, ra, rb, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
